// File: rtl/instruction_register_mb_if.sv
// Bus-side signals of the multi-byte instruction register.
// The slave side is the register itself. The master side is whoever drives the W bus and
// consumes the decoded instruction.
interface instruction_register_mb_if #(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int MAX_OPND = 2
);

  logic                         nLi;
  logic                         nEi;
  logic [DATA_W-1:0]            wbus;
  logic [OPCODE_W-1:0]          opcode;
  logic [MAX_OPND*DATA_W-1:0]   operand;
  logic [MAX_OPND*DATA_W-1:0]   bus_out;
  logic                         ready;
  logic                         busy;
  logic [1:0]                   byte_idx;

  modport master (
    output nLi, nEi, wbus,
    input  opcode, operand, bus_out, ready, busy, byte_idx
  );

  modport slave (
    input  nLi, nEi, wbus,
    output opcode, operand, bus_out, ready, busy, byte_idx
  );

endinterface

// File: rtl/instruction_register_mb.sv
// Multi-byte instruction register.
// An opcode byte is captured from the W bus, followed by 0..MAX_OPND operand bytes. The
// number of operand bytes is decoded from the top two opcode bits, or forced to zero in
// SAP-1 compatibility mode. The operand, or the low field of a short instruction, is
// driven back onto the W bus under an active-low enable.
// Legal parameter ranges: 2 <= OPCODE_W < DATA_W and 1 <= MAX_OPND <= 3.
module instruction_register_mb #(
  parameter int DATA_W          = 8,
  parameter int OPCODE_W        = 4,
  parameter int MAX_OPND        = 2,
  parameter int LEN_FROM_OPCODE = 1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  instruction_register_mb_if.slave bus
);

  localparam int OPND_W = MAX_OPND * DATA_W;
  localparam int LOW_W  = DATA_W - OPCODE_W;
  localparam logic [1:0] MAX_LEN = 2'(MAX_OPND);

  typedef enum logic {
    S_OPC,
    S_OPND
  } state_t;

  state_t               state, state_n;
  logic [OPCODE_W-1:0]  opcode_r, opcode_n;
  logic [LOW_W-1:0]     low_r, low_n;
  logic [OPND_W-1:0]    operand_r, operand_n;
  logic [1:0]           len_r, len_n;
  logic [1:0]           idx_r, idx_n;
  logic                 ready_r, ready_n;
  logic                 busy_r, busy_n;
  logic [OPND_W-1:0]    drive;

  // Operand count from the top two opcode bits. Encodings above MAX_OPND saturate.
  function automatic logic [1:0] sat_len(input logic [1:0] enc);
    if (LEN_FROM_OPCODE == 0) begin
      return 2'd0;
    end
    if (enc > MAX_LEN) begin
      return MAX_LEN;
    end
    return enc;
  endfunction

  // Next-state and next-register logic. Everything holds unless nLi is low.
  always_comb begin
    state_n   = state;
    opcode_n  = opcode_r;
    low_n     = low_r;
    operand_n = operand_r;
    len_n     = len_r;
    idx_n     = idx_r;
    ready_n   = ready_r;
    busy_n    = busy_r;
    if (!bus.nLi) begin
      unique case (state)
        S_OPC: begin
          opcode_n  = bus.wbus[DATA_W-1 -: OPCODE_W];
          low_n     = bus.wbus[LOW_W-1:0];
          operand_n = '0;
          len_n     = sat_len(bus.wbus[DATA_W-1 -: 2]);
          idx_n     = 2'd0;
          if (len_n == 2'd0) begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            ready_n = 1'b0;
            busy_n  = 1'b1;
            state_n = S_OPND;
          end
        end
        S_OPND: begin
          // Little-endian: operand byte k lands in bits [k*DATA_W +: DATA_W].
          for (int b = 0; b < MAX_OPND; b++) begin
            if (idx_r == 2'(b)) begin
              operand_n[b*DATA_W +: DATA_W] = bus.wbus;
            end
          end
          if (idx_r == len_r - 2'd1) begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
            idx_n   = 2'd0;
            state_n = S_OPC;
          end else begin
            idx_n = idx_r + 2'd1;
          end
        end
        default: state_n = S_OPC;
      endcase
    end
  end

  // State and instruction registers. Reset discards any partial instruction.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= S_OPC;
      opcode_r  <= '0;
      low_r     <= '0;
      operand_r <= '0;
      len_r     <= 2'd0;
      idx_r     <= 2'd0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_n;
      opcode_r  <= opcode_n;
      low_r     <= low_n;
      operand_r <= operand_n;
      len_r     <= len_n;
      idx_r     <= idx_n;
      ready_r   <= ready_n;
      busy_r    <= busy_n;
    end
  end

  // A short instruction exposes its zero-extended low field. A long instruction exposes
  // the operand register, including partially loaded values.
  always_comb begin
    drive = operand_r;
    if (len_r == 2'd0) begin
      drive = {{(OPND_W-LOW_W){1'b0}}, low_r};
    end
  end

  assign bus.bus_out  = bus.nEi ? {OPND_W{1'bz}} : drive;
  assign bus.opcode   = opcode_r;
  assign bus.operand  = operand_r;
  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.byte_idx = idx_r;

endmodule

// File: tb/tb_instruction_register_mb.sv
// Scoreboard bench for instruction_register_mb.
// One instance uses opcode-decoded lengths. A second instance runs in SAP-1 mode.
module tb_instruction_register_mb;

  logic CLK;
  logic CLR;

  instruction_register_mb_if #(.DATA_W(8), .OPCODE_W(4), .MAX_OPND(2)) ifc ();
  instruction_register_mb_if #(.DATA_W(8), .OPCODE_W(4), .MAX_OPND(2)) sif ();

  instruction_register_mb #(
    .DATA_W(8), .OPCODE_W(4), .MAX_OPND(2), .LEN_FROM_OPCODE(1)
  ) dut (
    .CLK(CLK), .CLR(CLR), .bus(ifc.slave)
  );

  instruction_register_mb #(
    .DATA_W(8), .OPCODE_W(4), .MAX_OPND(2), .LEN_FROM_OPCODE(0)
  ) dut_sap (
    .CLK(CLK), .CLR(CLR), .bus(sif.slave)
  );

  typedef struct {
    bit          sap;
    string       tag;
    logic [3:0]  op;
    logic [15:0] opnd;
    logic        rdy;
    logic        bsy;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops one expectation and compares it against the matching instance.
  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    if (e.sap) begin
      chk({e.tag, "_op"},   64'(sif.opcode),   64'(e.op));
      chk({e.tag, "_opnd"}, 64'(sif.operand),  64'(e.opnd));
      chk({e.tag, "_rdy"},  64'(sif.ready),    64'(e.rdy));
      chk({e.tag, "_bsy"},  64'(sif.busy),     64'(e.bsy));
      chk({e.tag, "_idx"},  64'(sif.byte_idx), 64'(e.idx));
    end else begin
      chk({e.tag, "_op"},   64'(ifc.opcode),   64'(e.op));
      chk({e.tag, "_opnd"}, 64'(ifc.operand),  64'(e.opnd));
      chk({e.tag, "_rdy"},  64'(ifc.ready),    64'(e.rdy));
      chk({e.tag, "_bsy"},  64'(ifc.busy),     64'(e.bsy));
      chk({e.tag, "_idx"},  64'(ifc.byte_idx), 64'(e.idx));
    end
  endtask

  // One clock edge, optionally loading a byte, then scoreboard compare.
  task automatic step(input bit sap, input bit load, input logic [7:0] b, input string tag,
                      input logic [3:0] op, input logic [15:0] opnd,
                      input logic rdy, input logic bsy, input logic [1:0] idx);
    exp_t e;
    e.sap = sap; e.tag = tag; e.op = op; e.opnd = opnd; e.rdy = rdy; e.bsy = bsy; e.idx = idx;
    sb.push_back(e);
    if (sap) begin
      sif.nLi  = ~load;
      sif.wbus = b;
    end else begin
      ifc.nLi  = ~load;
      ifc.wbus = b;
    end
    @(posedge CLK);
    #1;
    ifc.nLi = 1'b1;
    sif.nLi = 1'b1;
    compare_next();
  endtask

  // Checks the bus drive with nEi low, then that the bus is released with nEi high.
  // A released bus may resolve to zeros in a two-state simulator.
  task automatic bus_chk(input string tag, input logic [15:0] exp);
    ifc.nEi = 1'b0;
    #1;
    chk({tag, "_drv"}, 64'(ifc.bus_out), 64'(exp));
    ifc.nEi = 1'b1;
    #1;
    chk({tag, "_rel"}, 64'((ifc.bus_out === 16'hzzzz) || (ifc.bus_out === 16'h0000)), 64'd1);
  endtask

  initial begin
    ifc.nLi = 1'b1; ifc.nEi = 1'b1; ifc.wbus = '0;
    sif.nLi = 1'b1; sif.nEi = 1'b1; sif.wbus = '0;
    CLR = 1'b0;
    #12;
    CLR = 1'b1;
    @(posedge CLK);
    #1;

    // Length-0 instruction
    step(0, 1, 8'h2A, "len0", 4'h2, 16'h0000, 1, 0, 2'd0);
    bus_chk("len0_bus", 16'h000A);

    // Asynchronous reset between edges
    #1;
    CLR = 1'b0;
    #1;
    chk("rst_op",  64'(ifc.opcode), 64'd0);
    chk("rst_rdy", 64'(ifc.ready),  64'd0);
    chk("rst_bsy", 64'(ifc.busy),   64'd0);
    bus_chk("rst_bus", 16'h0000);
    CLR = 1'b1;

    // Length-1 instruction with idle cycles in between
    step(0, 1, 8'h4E, "len1_opc", 4'h4, 16'h0000, 0, 1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hFF, "len1_hold", 4'h4, 16'h0000, 0, 1, 2'd0);
    end
    step(0, 1, 8'h37, "len1_b0", 4'h4, 16'h0037, 1, 0, 2'd0);
    bus_chk("len1_bus", 16'h0037);

    // Length-2 instruction, partial value visible while busy
    step(0, 1, 8'h8F, "len2_opc", 4'h8, 16'h0000, 0, 1, 2'd0);
    step(0, 1, 8'h34, "len2_b0",  4'h8, 16'h0034, 0, 1, 2'd1);
    bus_chk("len2_part", 16'h0034);
    step(0, 1, 8'h12, "len2_b1",  4'h8, 16'h1234, 1, 0, 2'd0);
    bus_chk("len2_bus", 16'h1234);

    // Encoded count 3 saturates to 2, then a back-to-back short instruction
    step(0, 1, 8'hC0, "sat_opc", 4'hC, 16'h0000, 0, 1, 2'd0);
    step(0, 1, 8'hAA, "sat_b0",  4'hC, 16'h00AA, 0, 1, 2'd1);
    step(0, 1, 8'hBB, "sat_b1",  4'hC, 16'hBBAA, 1, 0, 2'd0);
    step(0, 1, 8'h2A, "b2b_len0", 4'h2, 16'h0000, 1, 0, 2'd0);
    bus_chk("b2b_bus", 16'h000A);

    // Reset mid-instruction, with a load attempted while reset is held
    step(0, 1, 8'h8F, "mid_opc", 4'h8, 16'h0000, 0, 1, 2'd0);
    step(0, 1, 8'h34, "mid_b0",  4'h8, 16'h0034, 0, 1, 2'd1);
    #1;
    CLR = 1'b0;
    ifc.nLi = 1'b0;
    ifc.wbus = 8'h2A;
    @(posedge CLK);
    #1;
    ifc.nLi = 1'b1;
    chk("rstwin_op",   64'(ifc.opcode),   64'd0);
    chk("rstwin_opnd", 64'(ifc.operand),  64'd0);
    chk("rstwin_rdy",  64'(ifc.ready),    64'd0);
    chk("rstwin_bsy",  64'(ifc.busy),     64'd0);
    chk("rstwin_idx",  64'(ifc.byte_idx), 64'd0);
    CLR = 1'b1;
    #2;
    step(0, 1, 8'h55, "post_rst", 4'h5, 16'h0000, 0, 1, 2'd0);

    // SAP-1 mode: every instruction is one byte
    step(1, 1, 8'h8F, "sap_a", 4'h8, 16'h0000, 1, 0, 2'd0);
    sif.nEi = 1'b0;
    #1;
    chk("sap_bus", 64'(sif.bus_out), 64'h000F);
    sif.nEi = 1'b1;
    step(1, 1, 8'h34, "sap_b", 4'h3, 16'h0000, 1, 0, 2'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
